// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the dual-issue scheduler and its scoreboard.
package issue_scheduler_pkg;

  localparam int REG_W    = 3;
  localparam int NREG     = 8;
  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 3;
  localparam int CNT_W    = 2;

  typedef enum logic {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/issue_scheduler_scoreboard.sv
// Per-register countdown of results that forwarding cannot yet supply
// (load data, multiply results), plus the multiplier occupancy counter.
module sched_scoreboard
  import issue_scheduler_pkg::*;
#(
  parameter int P_NREG     = NREG,
  parameter int P_CNT_W    = CNT_W,
  parameter int P_LOAD_LAT = LOAD_LAT,
  parameter int P_MUL_LAT  = MUL_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load_set,
  input  logic [REG_W-1:0]   i_load_rd,
  input  logic               i_mul_set,
  input  logic [REG_W-1:0]   i_mul_rd,
  output logic [P_NREG-1:0]  o_busy_vec,
  output logic               o_mul_busy
);

  logic [P_CNT_W-1:0] r_mulcnt;
  logic [P_CNT_W-1:0] w_mulcnt_next;
  logic               w_mul_hit_any;

  // r0 is hard-wired, so a write to it never needs tracking.
  assign w_mul_hit_any = i_mul_set && (i_mul_rd != '0);

  genvar gi;
  generate
    for (gi = 0; gi < P_NREG; gi++) begin : g_reg
      logic [P_CNT_W-1:0] r_cnt;
      logic               r_busy;
      logic [P_CNT_W-1:0] w_cnt_next;
      logic               w_load_hit;
      logic               w_mul_hit;

      assign w_load_hit = i_load_set && (i_load_rd == REG_W'(gi)) && (gi != 0);
      assign w_mul_hit  = i_mul_set  && (i_mul_rd  == REG_W'(gi)) && (gi != 0);

      // Next count: a new producer reloads the counter, otherwise count down to zero.
      always_comb begin
        w_cnt_next = r_cnt;
        if (w_mul_hit) begin
          w_cnt_next = P_CNT_W'(P_MUL_LAT);
        end else if (w_load_hit) begin
          w_cnt_next = P_CNT_W'(P_LOAD_LAT);
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      // Counter and its registered busy flag stay in lockstep.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt  <= '0;
          r_busy <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_next;
          r_busy <= (w_cnt_next != '0);
        end
      end

      assign o_busy_vec[gi] = r_busy;
    end
  endgenerate

  // Multiplier occupancy follows the same reload/countdown rule as a register.
  always_comb begin
    w_mulcnt_next = r_mulcnt;
    if (w_mul_hit_any) begin
      w_mulcnt_next = P_CNT_W'(P_MUL_LAT);
    end else if (r_mulcnt != '0) begin
      w_mulcnt_next = r_mulcnt - 1'b1;
    end
  end

  // Multiplier occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mulcnt <= '0;
    end else begin
      r_mulcnt <= w_mulcnt_next;
    end
  end

  assign o_mul_busy = (r_mulcnt != '0);

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue ID-stage scheduler: hazard checks, pair split/stall FSM,
// IF/ID hold and ID/EX issue strobes. Decisions are combinational so they
// act in the same cycle; state and scoreboard advance on the clock.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int P_NREG     = NREG,
  parameter int P_LOAD_LAT = LOAD_LAT,
  parameter int P_MUL_LAT  = MUL_LAT,
  parameter int P_CNT_W    = CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid1,
  input  logic              valid2,
  input  logic [REG_W-1:0]  rd1,
  input  logic [REG_W-1:0]  rs1a,
  input  logic [REG_W-1:0]  rs1b,
  input  logic              we1,
  input  logic              mul1,
  input  logic [REG_W-1:0]  rd2,
  input  logic [REG_W-1:0]  rs2a,
  input  logic [REG_W-1:0]  rs2b,
  input  logic              we2,
  input  logic              load2,
  output logic              issue1,
  output logic              issue2,
  output logic              hold_ifid,
  output logic              split,
  output logic [P_NREG-1:0] busy_vec
);

  sched_state_e r_state;
  sched_state_e w_state_next;
  logic         r_split;

  logic w_mul_busy;
  logic w_ok1;
  logic w_ok2;
  logic w_dep;
  logic w_issue1;
  logic w_issue2;
  logic w_hold;

  function automatic logic reg_busy(input logic [P_NREG-1:0] vec, input logic [REG_W-1:0] r);
    return vec[r] && (r != '0);
  endfunction

  // Scoreboard only ever sees producers that actually issue.
  sched_scoreboard #(
    .P_NREG     (P_NREG),
    .P_CNT_W    (P_CNT_W),
    .P_LOAD_LAT (P_LOAD_LAT),
    .P_MUL_LAT  (P_MUL_LAT)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_load_set (w_issue2 && load2),
    .i_load_rd  (rd2),
    .i_mul_set  (w_issue1 && mul1),
    .i_mul_rd   (rd1),
    .o_busy_vec (busy_vec),
    .o_mul_busy (w_mul_busy)
  );

  // Per-slot readiness and the intra-pair RAW/WAW dependency.
  always_comb begin
    w_ok1 = valid1
            && !reg_busy(busy_vec, rs1a) && !reg_busy(busy_vec, rs1b)
            && !(we1 && reg_busy(busy_vec, rd1))
            && !(mul1 && w_mul_busy);
    w_ok2 = valid2
            && !reg_busy(busy_vec, rs2a) && !reg_busy(busy_vec, rs2b)
            && !(we2 && reg_busy(busy_vec, rd2));
    w_dep = we1 && (rd1 != '0)
            && ((rs2a == rd1) || (rs2b == rd1) || (we2 && (rd2 == rd1)));
  end

  // Issue decision; slot 2 never overtakes an unissued slot 1.
  always_comb begin
    w_issue1     = 1'b0;
    w_issue2     = 1'b0;
    w_hold       = 1'b0;
    w_state_next = r_state;
    if (flush) begin
      w_state_next = RUN;
    end else if (r_state == SPLIT) begin
      if (w_ok2) begin
        w_issue2     = 1'b1;
        w_state_next = RUN;
      end else begin
        w_hold = 1'b1;
      end
    end else if (valid1) begin
      if (w_ok1) begin
        w_issue1 = 1'b1;
        if (valid2) begin
          if (w_ok2 && !w_dep) begin
            w_issue2 = 1'b1;
          end else begin
            w_hold       = 1'b1;
            w_state_next = SPLIT;
          end
        end
      end else begin
        w_hold = 1'b1;
      end
    end else if (valid2) begin
      if (w_ok2) begin
        w_issue2 = 1'b1;
      end else begin
        w_hold = 1'b1;
      end
    end
  end

  // State register with the split flag registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_split <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_split <= (w_state_next == SPLIT);
    end
  end

  assign issue1    = w_issue1;
  assign issue2    = w_issue2;
  assign hold_ifid = w_hold;
  assign split     = r_split;

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench: directed scenarios followed by random pairs, all
// checked against an integer-array reference model of the issue rules.
module tb_issue_scheduler;

  localparam int LOAD_L = 1;
  localparam int MUL_L  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush, valid1, valid2, we1, mul1, we2, load2;
  logic [2:0] rd1, rs1a, rs1b, rd2, rs2a, rs2b;
  logic       issue1, issue2, hold_ifid, split;
  logic [7:0] busy_vec;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_cnt [8];
  int m_mul;
  bit m_split;

  issue_scheduler dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid1(valid1), .valid2(valid2),
    .rd1(rd1), .rs1a(rs1a), .rs1b(rs1b), .we1(we1), .mul1(mul1),
    .rd2(rd2), .rs2a(rs2a), .rs2b(rs2b), .we2(we2), .load2(load2),
    .issue1(issue1), .issue2(issue2), .hold_ifid(hold_ifid),
    .split(split), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    m_mul   = 0;
    m_split = 0;
  endtask

  function automatic bit mb(input int r);
    return (r != 0) && (m_cnt[r] != 0);
  endfunction

  function automatic logic [7:0] model_busy();
    logic [7:0] v;
    for (int r = 0; r < 8; r++) v[r] = (m_cnt[r] != 0);
    return v;
  endfunction

  task automatic idle_inputs();
    flush = 0; valid1 = 0; valid2 = 0; we1 = 0; mul1 = 0; we2 = 0; load2 = 0;
    rd1 = 0; rs1a = 0; rs1b = 0; rd2 = 0; rs2a = 0; rs2b = 0;
  endtask

  task automatic set1(input bit v, input int d, input int a, input int b, input bit w, input bit m);
    valid1 = v; rd1 = 3'(d); rs1a = 3'(a); rs1b = 3'(b); we1 = w; mul1 = m;
  endtask

  task automatic set2(input bit v, input int d, input int a, input int b, input bit w, input bit l);
    valid2 = v; rd2 = 3'(d); rs2a = 3'(a); rs2b = 3'(b); we2 = w; load2 = l;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  // Checks the cycle's decision mid-cycle, then advances the model at the edge.
  task automatic step(input string tag);
    bit ok1, ok2, dep, e1, e2, eh, ns;
    #4;
    ok1 = valid1 && !mb(rs1a) && !mb(rs1b) && !(we1 && mb(rd1)) && !(mul1 && m_mul != 0);
    ok2 = valid2 && !mb(rs2a) && !mb(rs2b) && !(we2 && mb(rd2));
    dep = we1 && rd1 != 0 && (rs2a == rd1 || rs2b == rd1 || (we2 && rd2 == rd1));
    e1 = 0; e2 = 0; eh = 0; ns = m_split;
    if (flush) begin
      ns = 0;
    end else if (m_split) begin
      if (ok2) begin e2 = 1; ns = 0; end
      else eh = 1;
    end else if (valid1 && ok1 && valid2) begin
      e1 = 1;
      if (ok2 && !dep) e2 = 1;
      else begin eh = 1; ns = 1; end
    end else if (valid1 && ok1) begin
      e1 = 1;
    end else if (valid1) begin
      eh = 1;
    end else if (valid2) begin
      if (ok2) e2 = 1; else eh = 1;
    end
    chk({tag, ".issue1"}, 32'(issue1), 32'(e1));
    chk({tag, ".issue2"}, 32'(issue2), 32'(e2));
    chk({tag, ".hold"},   32'(hold_ifid), 32'(eh));
    chk({tag, ".split"},  32'(split), 32'(m_split));
    chk({tag, ".busy"},   32'(busy_vec), 32'(model_busy()));
    $display("step %-10s v=%b%b rd1=%0d rs1=%0d,%0d m=%b rd2=%0d rs2=%0d,%0d l=%b fl=%b -> i=%b%b h=%b split=%b busy=%b",
             tag, valid1, valid2, rd1, rs1a, rs1b, mul1, rd2, rs2a, rs2b, load2, flush,
             issue1, issue2, hold_ifid, split, busy_vec);
    @(posedge clk);
    for (int r = 0; r < 8; r++) if (m_cnt[r] > 0) m_cnt[r]--;
    if (m_mul > 0) m_mul--;
    if (e2 && load2 && rd2 != 0) m_cnt[rd2] = LOAD_L;
    if (e1 && mul1 && rd1 != 0) begin m_cnt[rd1] = MUL_L; m_mul = MUL_L; end
    m_split = ns;
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    // reset state, nothing valid
    step("reset");

    // independent pair
    set1(1, 1, 2, 3, 1, 0); set2(1, 4, 5, 6, 1, 0);
    step("indep");

    // intra-pair RAW: split then issue slot 2
    set1(1, 3, 1, 2, 1, 0); set2(1, 6, 3, 4, 1, 0);
    step("raw0");
    step("raw1");

    // load-use: one stall
    set1(1, 1, 2, 3, 1, 0); set2(1, 5, 6, 7, 1, 1);
    step("ld");
    set1(1, 2, 5, 1, 1, 0); set2(0, 0, 0, 0, 0, 0);
    step("lduse0");
    step("lduse1");

    // mul then mul reading the result: three stalls
    set1(1, 2, 3, 4, 1, 1);
    step("mul");
    set1(1, 6, 2, 1, 1, 1);
    for (int k = 0; k < 4; k++) step($sformatf("mulrd%0d", k));

    // r0 load and r0 sources: no scoreboard, no stall
    set1(1, 1, 0, 0, 1, 0); set2(1, 0, 0, 0, 1, 1);
    step("r0a");
    set1(1, 3, 0, 0, 1, 0); set2(1, 4, 0, 0, 1, 0);
    step("r0b");

    // flush while in SPLIT with cnt[5]=1
    idle_inputs();
    set1(1, 5, 1, 1, 1, 1);
    step("mul5");
    set1(1, 1, 2, 3, 1, 0); set2(1, 4, 5, 0, 1, 0);
    step("fl0");
    step("fl1");
    flush = 1;
    step("flush");
    flush = 0; idle_inputs();
    step("flafter");

    // asynchronous reset mid-SPLIT with nonzero counters
    set1(1, 2, 3, 4, 1, 1);
    step("armul");
    set1(1, 1, 3, 4, 1, 0); set2(1, 5, 2, 0, 1, 0);
    step("arsplit");
    #3;
    reset = 1;
    #1;
    chk("areset.busy",  32'(busy_vec), 32'd0);
    chk("areset.split", 32'(split), 32'd0);
    $display("async reset mid-cycle -> split=%b busy=%b", split, busy_vec);
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    idle_inputs();
    step("postrst");

    // random pairs biased toward low registers to provoke hazards
    for (int k = 0; k < 300; k++) begin
      flush  = ($urandom_range(0, 19) == 0);
      set1($urandom_range(0, 4) != 0, $urandom_range(0, 4), $urandom_range(0, 4),
           $urandom_range(0, 4), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      set2($urandom_range(0, 4) != 0, $urandom_range(0, 4), $urandom_range(0, 4),
           $urandom_range(0, 4), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      step($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
